hex_scan_ctrl: RTL and testbench

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

---
 rtl/hex_scan_ctrl.sv | 113 +++++++++++
 tb/tb_hex_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed 7-segment hex display scanner with a double-buffered value
// that only swaps at frame boundaries, plus optional leading-zero blanking.
module hex_scan_ctrl #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        upd
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   active_q, active_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          upd_q, upd_d;

  logic          tick, frame, swap, blank;
  logic [3:0]    nib;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_comb begin
    tick      = enable && (cnt_q == CW'(DIV - 1));
    frame     = tick && (idx_q == 2'd3);
    swap      = frame && (pending_q || load);

    cnt_d     = cnt_q;
    if (enable) cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;

    shadow_d  = load ? value : shadow_q;
    pending_d = swap ? 1'b0 : (load ? 1'b1 : pending_q);
    // A load on the boundary itself bypasses the shadow so it shows this frame.
    active_d  = swap ? (load ? value : shadow_q) : active_q;
    upd_d     = swap;

    nib   = 4'h0;
    blank = 1'b0;
    case (idx_q)
      2'd0: nib = active_q[3:0];
      2'd1: begin nib = active_q[7:4];   blank = (active_q[15:4] == 12'h000); end
      2'd2: begin nib = active_q[11:8];  blank = (active_q[15:8] == 8'h00);   end
      default: begin nib = active_q[15:12]; blank = (active_q[15:12] == 4'h0); end
    endcase
    blank = blank && blank_lz;

    an_d  = 4'b1111;
    seg_d = 7'h7F;
    if (enable && !blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = glyph(nib);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      active_q  <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
      upd_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      upd_q     <= upd_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign upd = upd_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Randomised plus directed bench for hex_scan_ctrl; a phase-count reference model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_hex_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd;

  hex_scan_ctrl #(.DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .enable   (enable),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       upd;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: total enabled cycles since reset fixes digit and tick position.
  int          m_phase   = 0;
  logic [15:0] m_shadow  = 16'h0000;
  logic [15:0] m_active  = 16'h0000;
  bit          m_pending = 1'b0;
  logic [6:0]  glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin : model
    exp_t        e;
    int          d;
    logic [15:0] upper;
    bit          bnd, sw;
    if (reset) begin
      m_phase   = 0;
      m_shadow  = 16'h0000;
      m_active  = 16'h0000;
      m_pending = 1'b0;
      e         = '{an: 4'hF, seg: 7'h7F, upd: 1'b0};
    end else begin
      d     = (m_phase / DIV) % 4;
      upper = m_active >> (4 * d);
      if (!enable || (blank_lz && d != 0 && upper == 16'h0000)) begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
      end else begin
        e.an  = ~(4'b0001 << d);
        e.seg = glyph_tbl[upper[3:0]];
      end
      bnd   = enable && ((m_phase % (4 * DIV)) == 4 * DIV - 1);
      sw    = bnd && (m_pending || load);
      e.upd = sw;
      if (sw) begin
        m_active  = load ? value : m_shadow;
        m_pending = 1'b0;
      end else if (load) begin
        m_pending = 1'b1;
      end
      if (load) m_shadow = value;
      if (enable) m_phase++;
    end
    sbq.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("an",  {8'h00, an},  {8'h00, e.an});
      check("seg", {5'h00, seg}, {5'h00, e.seg});
      check("upd", {11'h000, upd}, {11'h000, e.upd});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Advance until the model phase (value before the next edge) hits target modulo modv.
  task automatic wait_phase(input int modv, input int target, input string nm);
    int k = 0;
    while ((m_phase % modv) != target && k < 100) begin
      cyc(1);
      k++;
    end
    n_chk++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL %s: phase %0d never reached, stuck at %0d", nm, target, m_phase % modv);
    end
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    check(nm, {an, seg, upd}, {4'hF, 7'h7F, 1'b0});
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    cyc(1);
    load  = 1'b0;
  endtask

  initial begin
    cyc(2);
    check("reset_hold", {an, seg, upd}, {4'hF, 7'h7F, 1'b0});
    reset  = 1'b0;
    enable = 1'b1;
    cyc(20);

    // Load mid-frame, then a double load within one frame.
    wait_phase(4 * DIV, 5, "mid_frame");
    pulse_load(16'h1F80);
    cyc(36);
    wait_phase(4 * DIV, 2, "two_loads");
    pulse_load(16'h1111);
    cyc(3);
    pulse_load(16'h2222);
    cyc(36);

    // Load coincident with the frame boundary, with blanking.
    blank_lz = 1'b1;
    wait_phase(4 * DIV, 4 * DIV - 1, "boundary_load");
    pulse_load(16'h0005);
    cyc(34);

    // Drop enable partway through digit 2.
    wait_phase(4 * DIV, 2 * DIV + 1, "enable_drop");
    enable = 1'b0;
    cyc(10);
    enable = 1'b1;
    cyc(20);

    // Reset with a pending value: it must never appear.
    blank_lz = 1'b0;
    wait_phase(4 * DIV, 3, "reset_pending");
    pulse_load(16'hABCD);
    cyc(2);
    do_reset("reset_async");
    cyc(40);

    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) blank_lz = $urandom_range(0, 1) == 1;
      value  = 16'($urandom);
      load   = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) begin
        load = 1'b0;
        do_reset("reset_rand");
      end else begin
        cyc(1);
      end
    end
    load = 1'b0;
    enable = 1'b1;
    cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
